// File: rtl/nibble_disp.sv
// Time-multiplexed three-digit hex display: one data nibble plus a 6-bit address.
// Inputs are captured once per frame, so every frame shows one coherent snapshot.
module nibble_disp #(
  parameter int TICK_DIV  = 1000,
  parameter int BLANK_CYC = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] mem_data,
  input  logic [5:0] mem_addr,
  input  logic       blank,
  output logic [6:0] seg,
  output logic [2:0] digit_en,
  output logic       dp,
  output logic       frame_tick
);

  // state        | meaning
  // SLOT_DATA    | data digit (sh_data) on digit_en[0]
  // SLOT_ADDR_LO | address bits [3:0] on digit_en[1], dp lit
  // SLOT_ADDR_HI | address bits [5:4] on digit_en[2]
  typedef enum logic [1:0] {
    SLOT_DATA    = 2'd0,
    SLOT_ADDR_LO = 2'd1,
    SLOT_ADDR_HI = 2'd2
  } slot_t;

  localparam int            CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LIT  = CW'(BLANK_CYC);

  slot_t         slot;
  logic [CW-1:0] cnt;
  logic [3:0]    sh_data;
  logic [5:0]    sh_addr;
  logic          snap;
  logic          lit;
  logic [3:0]    nibble;
  logic [2:0]    slot_onehot;

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0:    font = 7'b0111111;
      4'h1:    font = 7'b0000110;
      4'h2:    font = 7'b1011011;
      4'h3:    font = 7'b1001111;
      4'h4:    font = 7'b1100110;
      4'h5:    font = 7'b1101101;
      4'h6:    font = 7'b1111101;
      4'h7:    font = 7'b0000111;
      4'h8:    font = 7'b1111111;
      4'h9:    font = 7'b1101111;
      4'hA:    font = 7'b1110111;
      4'hB:    font = 7'b1111100;
      4'hC:    font = 7'b0111001;
      4'hD:    font = 7'b1011110;
      4'hE:    font = 7'b1111001;
      default: font = 7'b1110001;
    endcase
  endfunction

  always_comb begin
    snap        = (cnt == '0) && (slot == SLOT_DATA);
    lit         = (cnt >= CNT_LIT) && !blank;
    nibble      = sh_data;
    slot_onehot = 3'b000;
    case (slot)
      SLOT_DATA: begin
        nibble      = sh_data;
        slot_onehot = 3'b001;
      end
      SLOT_ADDR_LO: begin
        nibble      = sh_addr[3:0];
        slot_onehot = 3'b010;
      end
      SLOT_ADDR_HI: begin
        nibble      = {2'b00, sh_addr[5:4]};
        slot_onehot = 3'b100;
      end
      default: begin
        nibble      = sh_data;
        slot_onehot = 3'b000;
      end
    endcase
  end

  // Outputs use the pre-edge slot/cnt/shadow; the snapshot edge is always dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      slot       <= SLOT_DATA;
      sh_data    <= 4'h0;
      sh_addr    <= 6'h00;
      seg        <= 7'b0000000;
      digit_en   <= 3'b000;
      dp         <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        case (slot)
          SLOT_DATA:    slot <= SLOT_ADDR_LO;
          SLOT_ADDR_LO: slot <= SLOT_ADDR_HI;
          default:      slot <= SLOT_DATA;
        endcase
      end else begin
        cnt <= cnt + CW'(1);
      end

      frame_tick <= snap;
      if (snap) begin
        sh_data <= mem_data;
        sh_addr <= mem_addr;
      end

      if (lit) begin
        digit_en <= slot_onehot;
        seg      <= font(nibble);
        dp       <= (slot == SLOT_ADDR_LO);
      end else begin
        digit_en <= 3'b000;
        seg      <= 7'b0000000;
        dp       <= 1'b0;
      end
    end
  end

endmodule
